// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction-queue fetch sequencer.
// Combinational only: no latency, no flow control.
package ifq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int LINE_BYTES = 16;
  localparam int WORD_OFS_W = 2;
  localparam int LINE_OFS_W = $clog2(LINE_BYTES);
  localparam int ADDR_W_MAX = 64;

  // Callers zero-extend their address into ADDR_W_MAX and truncate the result back.
  function automatic logic [ADDR_W_MAX-1:0] line_align(input logic [ADDR_W_MAX-1:0] addr);
    return addr & ~ADDR_W_MAX'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/ifq_line_buf.sv
// Line capture buffer: holds one returned cache line and the PC it belongs to.
// Load/clear act on the next edge (clear wins over load); the held line is stable until then.
module ifq_line_buf #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    LINE_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [LINE_WIDTH-1:0] ld_dat,
  input  logic [ADDR_WIDTH-1:0] ld_pc,
  output logic [LINE_WIDTH-1:0] line_dat,
  output logic [ADDR_WIDTH-1:0] line_pc
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      line_dat <= '0;
      line_pc  <= RESET_PC;
    end else if (clear) begin
      line_dat <= '0;
      line_pc  <= '0;
    end else if (load) begin
      line_dat <= ld_dat;
      line_pc  <= ld_pc;
    end
  end

endmodule

// File: rtl/ifq_fetch_ctrl.sv
// Fetch sequencer: one cache request outstanding, registered 1-cycle capture-to-queue-write; holds the line while i_q_full.
// Redirects reload the queue through the flush path; IFQ_PERF_CNT_EN adds saturating redirect/stall counters.
module ifq_fetch_ctrl
  import ifq_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    LINE_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_ic_req,
  output logic [ADDR_WIDTH-1:0] o_ic_addr,
  input  logic                  i_ic_valid,
  input  logic [LINE_WIDTH-1:0] i_ic_data,
  output logic [LINE_WIDTH-1:0] o_q_wdata,
  output logic                  o_q_w_en,
  output logic                  o_q_flush,
  output logic [WORD_OFS_W-1:0] o_q_jmp_b_3_2,
  input  logic                  i_q_full,
  input  logic                  i_q_empty,
  input  logic                  i_issue_rd,
  output logic                  o_q_rd_en,
  output logic [ADDR_WIDTH-1:0] o_fetch_pc
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]           o_redirect_cnt,
  output logic [31:0]           o_full_stall_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] RESET_LINE = ADDR_WIDTH'(line_align(ADDR_W_MAX'(RESET_PC)));

  fetch_state_e            state_q, state_d;
  logic                    redir_pend_q, redir_pend_d;
  logic [ADDR_WIDTH-1:0]   line_addr_q, line_addr_d;
  logic [WORD_OFS_W-1:0]   word_ofs_q, word_ofs_d;

  logic [ADDR_WIDTH-1:0]   redir_line;
  logic [ADDR_WIDTH-1:0]   req_pc;
  logic                    buf_load;
  logic                    buf_clear;
  logic [LINE_WIDTH-1:0]   line_dat;
  logic [ADDR_WIDTH-1:0]   line_pc;

  assign redir_line = ADDR_WIDTH'(line_align(ADDR_W_MAX'(i_redirect_pc)));

  // The word offset only applies to the first line after a redirect.
  assign req_pc = {line_addr_q[ADDR_WIDTH-1:LINE_OFS_W],
                   word_ofs_q & {WORD_OFS_W{redir_pend_q}},
                   {(LINE_OFS_W-WORD_OFS_W){1'b0}}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      redir_pend_q <= 1'b1;
      line_addr_q  <= RESET_LINE;
      word_ofs_q   <= RESET_PC[LINE_OFS_W-1 -: WORD_OFS_W];
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      line_addr_q  <= line_addr_d;
      word_ofs_q   <= word_ofs_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    redir_pend_d = redir_pend_q;
    line_addr_d  = line_addr_q;
    word_ofs_d   = word_ofs_q;
    if (i_redirect) begin
      line_addr_d  = redir_line;
      word_ofs_d   = i_redirect_pc[LINE_OFS_W-1 -: WORD_OFS_W];
      redir_pend_d = 1'b1;
      // A response still in flight must be swallowed before the next request; a
      // response arriving in this very cycle has already retired the old request.
      if ((state_q == REQ || state_q == DRAIN) && !i_ic_valid)
        state_d = DRAIN;
      else
        state_d = REQ;
    end else begin
      unique case (state_q)
        IDLE:  state_d = REQ;
        REQ:   if (i_ic_valid) state_d = WRITE;
        WRITE: begin
          if (redir_pend_q || !i_q_full) begin
            redir_pend_d = 1'b0;
            line_addr_d  = line_addr_q + ADDR_WIDTH'(LINE_BYTES);
            state_d      = REQ;
          end
        end
        DRAIN: if (i_ic_valid) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_ic_req  = 1'b0;
    o_q_w_en  = 1'b0;
    o_q_flush = 1'b0;
    buf_load  = 1'b0;
    unique case (state_q)
      REQ: begin
        o_ic_req = 1'b1;
        buf_load = i_ic_valid && !i_redirect;
      end
      WRITE: begin
        if (!i_redirect) begin
          o_q_flush = redir_pend_q;
          o_q_w_en  = !redir_pend_q && !i_q_full;
        end
      end
      default: ;
    endcase
    buf_clear  = i_redirect && (state_q == WRITE || state_q == IDLE);
    o_q_rd_en  = i_issue_rd && !i_q_empty && !redir_pend_q && !i_redirect;
    o_fetch_pc = (state_q == WRITE) ? line_pc : req_pc;
  end

  assign o_ic_addr     = line_addr_q;
  assign o_q_wdata     = line_dat;
  assign o_q_jmp_b_3_2 = line_pc[LINE_OFS_W-1 -: WORD_OFS_W];

  ifq_line_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LINE_WIDTH (LINE_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_line_buf (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .ld_dat   (i_ic_data),
    .ld_pc    (req_pc),
    .line_dat (line_dat),
    .line_pc  (line_pc)
  );

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_redirect_cnt   <= '0;
      o_full_stall_cnt <= '0;
    end else begin
      if (i_redirect && o_redirect_cnt != '1)
        o_redirect_cnt <= o_redirect_cnt + 32'd1;
      if (state_q == WRITE && i_q_full && !redir_pend_q && o_full_stall_cnt != '1)
        o_full_stall_cnt <= o_full_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
// Self-checking bench for ifq_fetch_ctrl: transaction-level cache/queue model with a scoreboard.
module tb_ifq_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_redirect = 1'b0;
  logic [31:0]  i_redirect_pc = '0;
  logic         o_ic_req;
  logic [31:0]  o_ic_addr;
  logic         i_ic_valid = 1'b0;
  logic [127:0] i_ic_data = '0;
  logic [127:0] o_q_wdata;
  logic         o_q_w_en;
  logic         o_q_flush;
  logic [1:0]   o_q_jmp_b_3_2;
  logic         i_q_full = 1'b0;
  logic         i_q_empty = 1'b1;
  logic         i_issue_rd = 1'b0;
  logic         o_q_rd_en;
  logic [31:0]  o_fetch_pc;

  ifq_fetch_ctrl dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_ic_req      (o_ic_req),
    .o_ic_addr     (o_ic_addr),
    .i_ic_valid    (i_ic_valid),
    .i_ic_data     (i_ic_data),
    .o_q_wdata     (o_q_wdata),
    .o_q_w_en      (o_q_w_en),
    .o_q_flush     (o_q_flush),
    .o_q_jmp_b_3_2 (o_q_jmp_b_3_2),
    .i_q_full      (i_q_full),
    .i_q_empty     (i_q_empty),
    .i_issue_rd    (i_issue_rd),
    .o_q_rd_en     (o_q_rd_en),
    .o_fetch_pc    (o_fetch_pc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic         flush;
    logic [127:0] dat;
    logic [1:0]   jmp;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int errs = 0;
  int checks = 0;

  // Cache model: one request at a time, answered lat cycles after acceptance.
  bit  outst = 0;
  int  cnt = 0;
  int  lat = 1;
  int  epoch = 0;
  int  req_ep = -1;
  bit  force_vld = 0;

  // Architectural expectations.
  bit           pend = 1, rd_pend = 1;
  bit           pl_vld = 0, pl_flush = 0;
  logic [127:0] pl_dat = '0;
  logic [31:0]  exp_addr = RPC;
  logic [1:0]   exp_ofs = 2'b00;
  bit           exp_we, exp_fl;

  bit rand_mode = 0;
  int p_full = 30, p_redir = 4;
  int idle = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    i_ic_valid = force_vld || (outst && cnt == 0);
    i_ic_data  = i_ic_valid ? {$urandom, $urandom, $urandom, $urandom} : '0;
    force_vld  = 0;
    i_redirect = 1'b0;
    if (rand_mode) begin
      lat        = $urandom_range(4, 1);
      i_q_full   = ($urandom_range(99) < p_full);
      i_issue_rd = $urandom_range(1);
      i_q_empty  = ($urandom_range(3) == 0);
      if (($urandom_range(99) < p_redir) && (!i_ic_valid || req_ep == epoch)) begin
        i_redirect    = 1'b1;
        i_redirect_pc = $urandom;
      end
    end
  endtask

  // Reference model: predicts strobe timing, request addresses and read gating.
  initial forever begin
    @(negedge i_clk);
    if (i_rst) begin
      epoch++;
      outst    = 0;
      pl_vld   = 0;
      sb.delete();
      pend     = 1;
      rd_pend  = 1;
      exp_addr = RPC;
      exp_ofs  = RPC[3:2];
    end else begin
      exp_we = pl_vld && !pl_flush && !i_q_full && !i_redirect;
      exp_fl = pl_vld && pl_flush && !i_redirect;
      chk("w_en_timing", o_q_w_en, exp_we);
      chk("flush_timing", o_q_flush, exp_fl);
      if (pl_vld && !i_redirect) begin
        chk("req_while_held", o_ic_req, 1'b0);
        chk("buf_stable", o_q_wdata, pl_dat);
      end
      chk("rd_gate", o_q_rd_en, i_issue_rd && !i_q_empty && !i_redirect && !rd_pend);
      if (exp_we || exp_fl || i_redirect) pl_vld = 0;
      if (exp_fl) rd_pend = 0;
      if (i_ic_valid) begin
        if (outst && req_ep == epoch && !i_redirect) begin
          sb.push_back('{flush: pend, dat: i_ic_data, jmp: exp_ofs});
          pl_vld   = 1;
          pl_flush = pend;
          pl_dat   = i_ic_data;
          pend     = 0;
          exp_addr = exp_addr + 32'd16;
        end
        outst = 0;
      end else if (outst) begin
        cnt--;
      end else if (o_ic_req) begin
        chk("req_addr", o_ic_addr, exp_addr);
        outst  = 1;
        cnt    = lat - 1;
        req_ep = epoch;
      end
      if (i_redirect) begin
        epoch++;
        exp_addr = {i_redirect_pc[31:4], 4'b0000};
        exp_ofs  = i_redirect_pc[3:2];
        pend     = 1;
        rd_pend  = 1;
        pl_vld   = 0;
        sb.delete();
      end
    end
  end

  // Monitor: every queue write/flush the DUT presents must match the next expected line.
  initial forever begin
    @(negedge i_clk);
    #1;
    if (i_rst) begin
      idle = 0;
    end else begin
      chk("w_en_flush_excl", o_q_w_en & o_q_flush, 1'b0);
      if (o_q_w_en || o_q_flush) begin
        idle = 0;
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL sb_underflow: queue write with no expected line (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("sb_flush", o_q_flush, e.flush);
          chk("sb_data", o_q_wdata, e.dat);
          if (e.flush) chk("sb_jmp", o_q_jmp_b_3_2, e.jmp);
        end
      end else if (++idle > 400) begin
        checks++;
        errs++;
        $display("FAIL watchdog: no queue write for 400 cycles (t=%0t)", $time);
        idle = 0;
      end
    end
  end

  initial begin
    lat        = 1;
    i_issue_rd = 1'b1;
    i_q_empty  = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    #2;
    chk("rst_ic_req", o_ic_req, 1'b0);
    chk("rst_w_en", o_q_w_en, 1'b0);
    chk("rst_flush", o_q_flush, 1'b0);
    chk("rst_rd_en", o_q_rd_en, 1'b0);
    chk("rst_wdata", o_q_wdata, 128'd0);
    chk("rst_jmp", o_q_jmp_b_3_2, RPC[3:2]);
    chk("rst_fetch_pc", o_fetch_pc, RPC);
    tick(); #2;
    chk("first_req_cycle2", o_ic_req, 1'b1);
    chk("first_req_addr", o_ic_addr, RPC);
    tick(); tick(); #2;
    chk("first_flush_cycle4", o_q_flush, 1'b1);
    chk("first_flush_jmp", o_q_jmp_b_3_2, 2'b00);

    // Queue full while a line waits in WRITE.
    i_q_full = 1'b1;
    repeat (20) tick();
    i_q_full = 1'b0;
    repeat (8) tick();

    // Redirect during REQ with a slow cache: old line must be drained.
    lat = 3;
    for (int k = 0; k < 50 && !(o_ic_req && !outst); k++) tick();
    chk("wait_req_start", o_ic_req && !outst, 1'b1);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0040_0128;
    repeat (20) tick();

    // Redirect in the same cycle as the cache response.
    lat = 2;
    for (int k = 0; k < 50 && !(i_ic_valid && req_ep == epoch); k++) tick();
    chk("wait_resp", i_ic_valid && req_ep == epoch, 1'b1);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0050_0044;
    tick(); #2;
    chk("redir_vld_req", o_ic_req, 1'b1);
    chk("redir_vld_addr", o_ic_addr, 32'h0050_0040);
    repeat (12) tick();

    // Address wrap at the top of the space.
    lat = 1;
    for (int k = 0; k < 50 && i_ic_valid; k++) tick();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'hFFFF_FFF4;
    repeat (12) tick();

    // Reset mid-request, then a stale response arrives while idle.
    lat = 3;
    for (int k = 0; k < 50 && !(o_ic_req && outst); k++) tick();
    chk("wait_inflight", o_ic_req && outst, 1'b1);
    i_rst     = 1'b1;
    force_vld = 1;
    tick();
    i_rst = 1'b0;
    #2;
    chk("idle_after_rst", o_ic_req, 1'b0);
    chk("idle_fetch_pc", o_fetch_pc, RPC);
    repeat (12) tick();

    rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0;
    i_q_full  = 1'b0;
    repeat (30) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ifq_fetch_ctrl.md
# ifq_fetch_ctrl

Fetch sequencer for the 4-entry × 128-bit instruction queue in the RISC-V front end. It fetches 16-byte lines from the instruction cache and writes them into the queue while the queue has room. On a branch or jump redirect it reloads the queue through the flush path. It also gates issue-side reads so that stale instructions are never dispatched.

## Interface
- ADDR_WIDTH, 32, instruction address width
- LINE_WIDTH, 128, cache line / queue entry width (4 instructions)
- RESET_PC, 32'h0040_0000, first fetch address after reset
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock, synchronous, active-high
- i_redirect  in  1  taken branch/jump this cycle
- i_redirect_pc  in  ADDR_WIDTH  redirect target
- o_ic_req  out  1  cache line request, held until i_ic_valid
- o_ic_addr  out  ADDR_WIDTH  line-aligned request address ([3:0]=0)
- i_ic_valid  in  1  line returned this cycle
- i_ic_data  in  LINE_WIDTH  returned line
- o_q_wdata  out  LINE_WIDTH  queue write data
- o_q_w_en  out  1  queue write
- o_q_flush  out  1  queue flush; o_q_wdata loaded into entry 0
- o_q_jmp_b_3_2  out  2  word offset of the first valid instruction after a flush
- i_q_full, i_q_empty  in  1  queue status
- i_issue_rd  in  1  issue stage requests an instruction
- o_q_rd_en  out  1  queue read
- o_fetch_pc  out  ADDR_WIDTH  PC of the line held or requested

## Operation
- The state register fetch_state_e has four states: IDLE, REQ, WRITE, DRAIN.
- The flag redir_pend marks that the next written line must use the flush path.
- The line_addr register holds the current line address.
- **IDLE** is entered only on reset. It moves to REQ on the next cycle.
- **REQ**:
  - o_ic_req=1 and o_ic_addr=line_addr.
  - On i_ic_valid, i_ic_data is captured into the line buffer and the state moves to WRITE.
- **WRITE**:
  - If redir_pend=1, drive o_q_flush=1 with o_q_jmp_b_3_2=line_pc[3:2]. i_q_full is ignored. Then clear redir_pend.
  - Otherwise, if !i_q_full, drive o_q_w_en=1. If i_q_full, stay in WRITE with the buffer held.
  - On a write or flush: line_addr += 16 (wraps modulo 2^ADDR_WIDTH) and the state moves to REQ.
- **Redirect**. i_redirect has priority over every other event in every state:
  - line_addr = {i_redirect_pc[ADDR_WIDTH-1:4],4'b0}, the low word offset is stored, and redir_pend=1.
  - From REQ without i_ic_valid: go to DRAIN, because the in-flight response must be discarded.
  - From REQ with i_ic_valid in the same cycle: drop the data and go to REQ.
  - From WRITE or IDLE: drop the buffer and go to REQ. No w_en or flush is asserted that cycle.
  - From DRAIN: update the target and stay in DRAIN.
- **DRAIN**: o_ic_req=0. On i_ic_valid, discard the data and go to REQ.
- **Read gating**: o_q_rd_en = i_issue_rd & !i_q_empty & !redir_pend & !i_redirect. This is combinational.
- o_q_w_en and o_q_flush are never asserted together.

## Timing
- Reset values:
  - state=IDLE, redir_pend=1, line_addr=RESET_PC aligned.
  - All strobes are 0: o_ic_req, o_q_w_en, o_q_flush, o_q_rd_en.
  - o_q_wdata=0, o_q_jmp_b_3_2=RESET_PC[3:2], o_fetch_pc=RESET_PC.
- The first cache request is issued in the 2nd cycle after i_rst deasserts.
- Latency from i_ic_valid to the queue write or flush is 1 cycle. This is registered, not combinational.
- Redirect to first valid read:
  - Best case: cache latency + 2 cycles (REQ, capture, WRITE+flush); o_q_rd_en can assert the cycle after the flush edge.
  - Add one full cache latency when a DRAIN is needed.
- Minimum period between writes is 2 cycles plus cache latency. Only one request is outstanding at a time.
- If i_rst is asserted mid-request, everything returns to IDLE. A stale i_ic_valid arriving in IDLE is ignored.

## Configuration
- IFQ_PERF_CNT_EN defined:
  - Adds outputs o_redirect_cnt[31:0] (count of i_redirect cycles) and o_full_stall_cnt[31:0] (cycles in WRITE with i_q_full and !redir_pend).
  - Both counters saturate and are cleared by i_rst.
- IFQ_PERF_CNT_EN undefined: neither the ports nor the counters exist. Functional behaviour is identical.

## Structure
- Package ifq_pkg holds:
  - fetch_state_e
  - LINE_BYTES=16
  - WORD_OFS_W=2
  - function line_align()
- Sub-module ifq_line_buf holds the LINE_WIDTH capture register plus line_pc, with load/clear controls. The FSM and gating stay in ifq_fetch_ctrl.

## Test plan
- Reset, cache latency 1 → o_ic_addr=0x0040_0000 in cycle 2; flush with o_q_jmp_b_3_2=0 in cycle 4; next request addr 0x0040_0010.
- Queue held full (i_q_full=1) for 5 cycles in WRITE → no w_en, buffer stable, o_ic_req=0; write on the first not-full cycle, then addr +16.
- Redirect to 0x0040_0128 in REQ, cache latency 3 → DRAIN discards the old line; new request 0x0040_0120; flush with o_q_jmp_b_3_2=2'b10; o_q_rd_en=0 throughout.
- Redirect coinciding with i_ic_valid → data dropped, no w_en, immediate request for the target line.
- i_issue_rd=1 with i_q_empty=1 → o_q_rd_en=0; with redir_pend=1 → o_q_rd_en=0.
- line_addr=0xFFFF_FFF0 write → next request 0x0000_0000.
